// File: rtl/kmul_pkg.sv
// kmul_pkg: shared constants, half-width helper and stage payload types for
// karatsuba_mul_pipe.
// Optional macro KARATSUBA_MUL_SIGNED_EN adds a sign bit to each payload.
// Payload fields are sized for KMUL_MAX_WIDTH, so any even WIDTH from 4 to
// KMUL_MAX_WIDTH uses the same types. Narrower instances zero-extend into the
// fields, and synthesis removes the constant upper bits.
package kmul_pkg;

    localparam int unsigned KMUL_DEFAULT_WIDTH = 16;
    localparam int unsigned KMUL_MAX_WIDTH     = 32;

    // Half operand width H for a given operand width.
    function automatic int unsigned kmul_half(input int unsigned width);
        return width / 2;
    endfunction

    localparam int unsigned KMUL_MAX_H = kmul_half(KMUL_MAX_WIDTH);
    localparam int unsigned KMUL_PW    = 2 * KMUL_MAX_H;       // p1 / p0 width
    localparam int unsigned KMUL_MW    = 2 * KMUL_MAX_H + 2;   // pm width

    // S1 payload: split operands plus the half sums.
    typedef struct packed {
        logic [KMUL_MAX_H-1:0] a1;
        logic [KMUL_MAX_H-1:0] a0;
        logic [KMUL_MAX_H-1:0] b1;
        logic [KMUL_MAX_H-1:0] b0;
        logic [KMUL_MAX_H:0]   sa;
        logic [KMUL_MAX_H:0]   sb;
`ifdef KARATSUBA_MUL_SIGNED_EN
        logic                  sgn;
`endif
    } s1_t;

    // S2 payload: the three partial products.
    typedef struct packed {
        logic [KMUL_PW-1:0] p1;
        logic [KMUL_PW-1:0] p0;
        logic [KMUL_MW-1:0] pm;
`ifdef KARATSUBA_MUL_SIGNED_EN
        logic               sgn;
`endif
    } s2_t;

endpackage

// File: rtl/karatsuba_recombine.sv
// karatsuba_recombine: combinational Karatsuba recombination
//   sum = (p1 << WIDTH) + ((pm - p1 - p0) << H) + p0
// All intermediates are 2*WIDTH+2 bits wide. The sum is truncated to
// 2*WIDTH bits only at the end, so the middle term is never cut short.
// Ports: p1, p0 (2H bits), pm (2H+2 bits) in; sum (2*WIDTH bits) out.
module karatsuba_recombine
    import kmul_pkg::*;
#(
    parameter int unsigned WIDTH = KMUL_DEFAULT_WIDTH
) (
    input  logic [2*kmul_half(WIDTH)-1:0]   p1,
    input  logic [2*kmul_half(WIDTH)-1:0]   p0,
    input  logic [2*kmul_half(WIDTH)+1:0]   pm,
    output logic [2*WIDTH-1:0]              sum
);

    localparam int unsigned H  = kmul_half(WIDTH);
    localparam int unsigned IW = 2 * WIDTH + 2;

    logic [IW-1:0] mid;
    logic [IW-1:0] acc;

    // The middle term is non-negative, so the modular subtraction is exact.
    always_comb begin
        mid = IW'(pm) - IW'(p1) - IW'(p0);
        acc = (IW'(p1) << WIDTH) + (mid << H) + IW'(p0);
        sum = (2*WIDTH)'(acc);
    end

endmodule

// File: rtl/karatsuba_mul_pipe.sv
// karatsuba_mul_pipe: 3-stage Karatsuba multiplier with a valid/ready stream
// interface on both sides.
//   S1: split operands and half sums; S2: p1, p0, pm; S3: recombined result.
// Ports: clk, rst (synchronous, active high), in_valid/in_ready/a/b (input
// stream), out_valid/out_ready/result (output stream, result = a*b).
// Optional macro KARATSUBA_MUL_SIGNED_EN: the operands are two's complement.
// The pipeline multiplies magnitudes, and S3 applies the sign.
// WIDTH must be even and no larger than KMUL_MAX_WIDTH.
module karatsuba_mul_pipe
    import kmul_pkg::*;
#(
    parameter int unsigned WIDTH = KMUL_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned H  = kmul_half(WIDTH);
    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned MH = KMUL_MAX_H;

    logic             adv;
    logic             v1;
    logic             v2;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    s1_t              s1_d;
    s1_t              s1_q;
    s2_t              s2_d;
    s2_t              s2_q;
    logic [RW-1:0]    sum;
    logic [RW-1:0]    res_d;

    // All stages move together. Any free slot at the output lets them advance.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Operand magnitudes. Negating the most negative value gives 2^(WIDTH-1),
    // and that value still fits as an unsigned WIDTH-bit number.
    always_comb begin
`ifdef KARATSUBA_MUL_SIGNED_EN
        mag_a = a[WIDTH-1] ? WIDTH'(-a) : a;
        mag_b = b[WIDTH-1] ? WIDTH'(-b) : b;
`else
        mag_a = a;
        mag_b = b;
`endif
    end

    // S1 next: halves plus their (H+1)-bit sums.
    always_comb begin
        s1_d    = '0;
        s1_d.a1 = MH'(mag_a[WIDTH-1:H]);
        s1_d.a0 = MH'(mag_a[H-1:0]);
        s1_d.b1 = MH'(mag_b[WIDTH-1:H]);
        s1_d.b0 = MH'(mag_b[H-1:0]);
        s1_d.sa = (MH+1)'(mag_a[WIDTH-1:H]) + (MH+1)'(mag_a[H-1:0]);
        s1_d.sb = (MH+1)'(mag_b[WIDTH-1:H]) + (MH+1)'(mag_b[H-1:0]);
`ifdef KARATSUBA_MUL_SIGNED_EN
        s1_d.sgn = a[WIDTH-1] ^ b[WIDTH-1];
`endif
    end

    // S2 next: the three partial products.
    always_comb begin
        s2_d    = '0;
        s2_d.p1 = KMUL_PW'(s1_q.a1) * KMUL_PW'(s1_q.b1);
        s2_d.p0 = KMUL_PW'(s1_q.a0) * KMUL_PW'(s1_q.b0);
        s2_d.pm = KMUL_MW'(s1_q.sa) * KMUL_MW'(s1_q.sb);
`ifdef KARATSUBA_MUL_SIGNED_EN
        s2_d.sgn = s1_q.sgn;
`endif
    end

    karatsuba_recombine #(
        .WIDTH (WIDTH)
    ) u_recombine (
        .p1  ((2*H)'(s2_q.p1)),
        .p0  ((2*H)'(s2_q.p0)),
        .pm  ((2*H+2)'(s2_q.pm)),
        .sum (sum)
    );

    // S3 next: apply the sign carried down from S1.
    always_comb begin
`ifdef KARATSUBA_MUL_SIGNED_EN
        res_d = s2_q.sgn ? RW'(-sum) : sum;
`else
        res_d = sum;
`endif
    end

    // Valid bits and the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
        end else if (adv) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            if (v2) begin
                result <= res_d;
            end
        end
    end

    // Stage payloads. Reset is not needed because the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (adv) begin
            if (in_valid) begin
                s1_q <= s1_d;
            end
            if (v1) begin
                s2_q <= s2_d;
            end
        end
    end

endmodule

// File: tb/tb_karatsuba_mul_pipe.sv
// tb_karatsuba_mul_pipe: bench for karatsuba_mul_pipe.
// It drives two instances: WIDTH=8 and WIDTH=16.
// Honours KARATSUBA_MUL_SIGNED_EN in its expected values.
module tb_karatsuba_mul_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] r8;

    logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] r16;

    always #5 clk = ~clk;

    karatsuba_mul_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .result(r8)
    );

    karatsuba_mul_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .out_valid(ov16), .out_ready(or16), .result(r16)
    );

    typedef struct { logic [7:0]  a; logic [7:0]  b; logic [15:0] exp; } v8_t;
    typedef struct { logic [15:0] a; logic [15:0] b; logic [31:0] exp; } v16_t;
    typedef struct { logic [15:0] exp; int acc; bit lat; } e8_t;
    typedef struct { logic [31:0] exp; int acc; bit lat; } e16_t;

    e8_t         q8[$];
    e16_t        q16[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          acc8  = 0;
    bit          hold8 = 1'b0, hold16 = 1'b0;
    logic [15:0] held8;
    logic [31:0] held16;

    v8_t  t8[7];
    v16_t t16[5];
    v8_t  st8[3];

    // Reference products from plain integer arithmetic.
    function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y);
`ifdef KARATSUBA_MUL_SIGNED_EN
        int p;
        p = int'($signed(x)) * int'($signed(y));
`else
        int p;
        p = int'(x) * int'(y);
`endif
        return 16'(p);
    endfunction

    function automatic logic [31:0] model16(input logic [15:0] x, input logic [15:0] y);
`ifdef KARATSUBA_MUL_SIGNED_EN
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
`else
        longint p;
        p = longint'(x) * longint'(y);
`endif
        return 32'(p);
    endfunction

    function automatic logic [7:0] pick8();
        int unsigned r;
        r = $urandom_range(0, 7);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'hFF;
        if (r == 2) return 8'h80;
        return 8'($urandom);
    endfunction

    function automatic logic [15:0] pick16();
        int unsigned r;
        r = $urandom_range(0, 7);
        if (r == 0) return 16'h0000;
        if (r == 1) return 16'hFFFF;
        if (r == 2) return 16'h8000;
        return 16'($urandom);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Account for the transfers the coming edge will perform.
    task automatic account8(input logic [15:0] e, input bit lat);
        e8_t x;
        check("in_ready8", 64'(ir8), 64'(!ov8 || or8));
        if (hold8) begin
            check("stall_valid8", 64'(ov8), 64'd1);
            check("stall_result8", 64'(r8), 64'(held8));
        end
        hold8 = (ov8 === 1'b1) && !or8;
        held8 = r8;
        if (iv8 && ir8 === 1'b1) begin
            q8.push_back('{exp: e, acc: cyc, lat: lat});
            acc8++;
        end
        if (ov8 === 1'b1 && or8) begin
            if (q8.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected8: got result %0h with nothing pending", r8);
            end else begin
                x = q8.pop_front();
                check("result8", 64'(r8), 64'(x.exp));
                if (x.lat) check("latency8", 64'(cyc - x.acc), 64'd3);
            end
        end
    endtask

    task automatic account16(input logic [31:0] e, input bit lat);
        e16_t x;
        check("in_ready16", 64'(ir16), 64'(!ov16 || or16));
        if (hold16) begin
            check("stall_valid16", 64'(ov16), 64'd1);
            check("stall_result16", 64'(r16), 64'(held16));
        end
        hold16 = (ov16 === 1'b1) && !or16;
        held16 = r16;
        if (iv16 && ir16 === 1'b1) q16.push_back('{exp: e, acc: cyc, lat: lat});
        if (ov16 === 1'b1 && or16) begin
            if (q16.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected16: got result %0h with nothing pending", r16);
            end else begin
                x = q16.pop_front();
                check("result16", 64'(r16), 64'(x.exp));
                if (x.lat) check("latency16", 64'(cyc - x.acc), 64'd3);
            end
        end
    endtask

    task automatic step(input bit v8, input logic [7:0] x8, input logic [7:0] y8,
                        input logic [15:0] e8, input bit l8, input bit rr8,
                        input bit v16, input logic [15:0] x16, input logic [15:0] y16,
                        input logic [31:0] e16, input bit l16, input bit rr16);
        @(negedge clk);
        rst  = 1'b0;
        cyc++;
        iv8  = v8;  a8  = x8;  b8  = y8;  or8  = rr8;
        iv16 = v16; a16 = x16; b16 = y16; or16 = rr16;
        #1;
        account8(e8, l8);
        account16(e16, l16);
    endtask

    task automatic step8(input bit v, input logic [7:0] x, input logic [7:0] y,
                         input logic [15:0] e, input bit l, input bit rr);
        step(v, x, y, e, l, rr, 1'b0, 16'h0, 16'h0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        step8(1'b0, 8'h0, 8'h0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        iv8 = 1'b0; iv16 = 1'b0; or8 = 1'b0; or16 = 1'b0;
        repeat (n - 1) @(negedge clk);
        q8.delete();
        q16.delete();
        hold8  = 1'b0;
        hold16 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q8.size() != 0 || q16.size() != 0) && n < 60) begin
            idle();
            n++;
        end
        if (q8.size() != 0 || q16.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d/%0d products still pending after %0d cycles",
                     q8.size(), q16.size(), n);
        end
        repeat (4) idle();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
`ifdef KARATSUBA_MUL_SIGNED_EN
        t8  = '{'{8'hB8, 8'h0F, 16'hFBC8}, '{8'hFF, 8'hFF, 16'h0001},
                '{8'h80, 8'h7F, 16'hC080}, '{8'h80, 8'h80, 16'h4000},
                '{8'h00, 8'hAA, 16'h0000}, '{8'hFF, 8'h01, 16'hFFFF},
                '{8'h7F, 8'h7F, 16'h3F01}};
        t16 = '{'{16'hFFFF, 16'hFFFF, 32'h00000001}, '{16'h1234, 16'h5678, 32'h06260060},
                '{16'h0000, 16'hBEEF, 32'h00000000}, '{16'h8000, 16'h8000, 32'h40000000},
                '{16'h8000, 16'h7FFF, 32'hC0008000}};
        st8 = '{'{8'h80, 8'h7F, 16'hC080}, '{8'h03, 8'h05, 16'h000F},
                '{8'h00, 8'hAA, 16'h0000}};
`else
        t8  = '{'{8'hB8, 8'h0F, 16'h0AC8}, '{8'hFF, 8'hFF, 16'hFE01},
                '{8'h80, 8'h7F, 16'h3F80}, '{8'h03, 8'h05, 16'h000F},
                '{8'h00, 8'hAA, 16'h0000}, '{8'hAA, 8'h00, 16'h0000},
                '{8'h01, 8'hFF, 16'h00FF}};
        t16 = '{'{16'hFFFF, 16'hFFFF, 32'hFFFE0001}, '{16'h1234, 16'h5678, 32'h06260060},
                '{16'h0000, 16'hBEEF, 32'h00000000}, '{16'h8000, 16'h8000, 32'h40000000},
                '{16'hFFFF, 16'h0001, 32'h0000FFFF}};
        st8 = '{'{8'h80, 8'h7F, 16'h3F80}, '{8'h03, 8'h05, 16'h000F},
                '{8'h00, 8'hAA, 16'h0000}};
`endif

        // Reset state.
        do_reset(3);
        idle();
        check("reset_out_valid8", 64'(ov8), 64'd0);
        check("reset_in_ready8", 64'(ir8), 64'd1);
        check("reset_result8", 64'(r8), 64'd0);
        check("reset_out_valid16", 64'(ov16), 64'd0);
        check("reset_in_ready16", 64'(ir16), 64'd1);
        check("reset_result16", 64'(r16), 64'd0);

        // Table vectors, back to back, with a latency check on each product.
        for (int i = 0; i < 7; i++) begin
            if (i < 5)
                step(1'b1, t8[i].a, t8[i].b, t8[i].exp, 1'b1, 1'b1,
                     1'b1, t16[i].a, t16[i].b, t16[i].exp, 1'b1, 1'b1);
            else
                step(1'b1, t8[i].a, t8[i].b, t8[i].exp, 1'b1, 1'b1,
                     1'b0, 16'h0, 16'h0, 32'h0, 1'b0, 1'b1);
        end
        drain();

        // Three-product stream, then a 4-cycle stall with a new input offered.
        for (int i = 0; i < 3; i++)
            step8(1'b1, st8[i].a, st8[i].b, st8[i].exp, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step8(1'b1, 8'h55, 8'h55, model8(8'h55, 8'h55), 1'b0, 1'b0);
            check("stall_in_ready8", 64'(ir8), 64'd0);
        end
        drain();

        // Reset with three products in flight.
        for (int i = 0; i < 3; i++) begin
            logic [7:0] x, y;
            x = pick8();
            y = pick8();
            step8(1'b1, x, y, model8(x, y), 1'b0, 1'b1);
        end
        do_reset(1);
        idle();
        check("reset_flush_valid8", 64'(ov8), 64'd0);
        repeat (6) idle();
        step8(1'b1, 8'h0B, 8'h0D, 16'h008F, 1'b1, 1'b1);
        drain();

        // Random streams on both instances, with random backpressure.
        begin
            int start = acc8;
            int n = 0;
            while (acc8 - start < 10000 && n < 40000) begin
                logic [7:0]  x8, y8;
                logic [15:0] x16, y16;
                x8  = pick8();  y8  = pick8();
                x16 = pick16(); y16 = pick16();
                step($urandom_range(0, 9) < 8, x8, y8, model8(x8, y8), 1'b0,
                     $urandom_range(0, 3) != 0,
                     $urandom_range(0, 9) < 7, x16, y16, model16(x16, y16), 1'b0,
                     $urandom_range(0, 3) != 0);
                n++;
            end
            if (acc8 - start < 10000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL random_accept: only %0d inputs accepted in %0d cycles",
                         acc8 - start, n);
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/karatsuba_mul_pipe.md
KARATSUBA_MUL_PIPE -- requirements
Module: karatsuba_mul_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; SHALL be even and >= 4; H = WIDTH/2 denotes the half width.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  the operand pair on a, b is valid.
REQ-005 in_ready  output  1  the block accepts the operand pair this cycle.
REQ-006 a  input  WIDTH  multiplicand.
REQ-007 b  input  WIDTH  multiplier.
REQ-008 out_valid  output  1  the value on result is valid.
REQ-009 out_ready  input  1  the downstream consumer accepts result this cycle.
REQ-010 result  output  2*WIDTH  full-width product a*b.

Function
REQ-011 A transfer SHALL occur on any edge where the valid and ready signals of an interface are both 1; no other edge is a transfer.
REQ-012 The datapath SHALL be a 3-stage pipeline (S1, S2, S3), each stage with its own valid bit; result and out_valid SHALL be driven from S3.
REQ-013 S1 SHALL register the split operands a1/a0 and b1/b0 (upper/lower H bits) and the sums sa = a1+a0 and sb = b1+b0, each H+1 bits with no truncation.
REQ-014 S2 SHALL register p1 = a1*b1 (2H bits), p0 = a0*b0 (2H bits) and pm = sa*sb (2H+2 bits).
REQ-015 S3 SHALL register result = (p1 << WIDTH) + ((pm - p1 - p0) << H) + p0, with every intermediate computed at 2*WIDTH+2 bits and truncated to 2*WIDTH bits only at the end.
REQ-016 The middle term SHALL never be truncated to H or 2H bits, because the 8-bit concatenation form {p1,pm,p0} is incorrect.
REQ-017 Global advance enable adv = !out_valid || out_ready; all stages SHALL shift together only when adv = 1 and SHALL hold their contents otherwise.
REQ-018 in_ready SHALL equal adv; an input offered while adv = 0 SHALL NOT be captured.
REQ-019 Latency SHALL be exactly 3 cycles from input transfer to out_valid when no stall occurs; throughput SHALL be 1 product per cycle.
REQ-020 Bubbles (in_valid = 0 while adv = 1) SHALL propagate as invalid stages; result is don't-care while out_valid = 0.
REQ-021 While out_valid = 1 and out_ready = 0, result SHALL remain stable.
REQ-022 Products SHALL leave in acceptance order; no product is dropped or duplicated.
REQ-023 Boundary: a or b equal to 0 SHALL give 0; all-ones x all-ones SHALL give the exact value with no wrap.

Reset
REQ-024 When rst = 1 at an edge, the valid bits of S1, S2 and S3 SHALL clear, so out_valid = 0 on the next cycle.
REQ-025 Data registers need not reset, but result SHALL reset to 0.
REQ-026 Reset mid-operation SHALL discard all in-flight products; none SHALL emerge after reset.
REQ-027 in_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-028 Macro KARATSUBA_MUL_SIGNED_EN selects signed operation.
REQ-029 When KARATSUBA_MUL_SIGNED_EN is defined:
- a and b SHALL be treated as two's complement.
- S1 SHALL register the magnitudes of a and b plus the sign bit sgn = a[MSB] ^ b[MSB]; sgn travels with its stage.
- S3 SHALL negate the product when sgn = 1.
- Latency and the handshake SHALL be unchanged.
- The magnitude of the most negative value SHALL be handled at H+1-bit sum width without overflow.
REQ-030 When KARATSUBA_MUL_SIGNED_EN is undefined, operands SHALL be unsigned and no sign logic SHALL be present.

Structure
REQ-031 Package kmul_pkg SHALL hold:
- the default WIDTH constant;
- a function returning H;
- the stage payload typedefs (s1_t, s2_t), parameterised by width via localparams.
REQ-032 One sub-module, karatsuba_recombine, SHALL implement the purely combinational S3 formula of REQ-015. Its inputs are p1, p0 and pm; its output is the 2*WIDTH sum. It is instantiated once.

Verification
REQ-033 WIDTH=8, unsigned; a=0xB8, b=0x0F, out_ready=1 -> result=0x0AC8 with out_valid exactly 3 cycles after acceptance.
REQ-034 WIDTH=8, unsigned; a=0xFF, b=0xFF -> 0xFE01. WIDTH=16; a=0xFFFF, b=0xFFFF -> 0xFFFE0001.
REQ-035 Back-to-back stream of 0x80*0x7F, 0x03*0x05, 0x00*0xAA at WIDTH=8, then out_ready=0 for 4 cycles:
- The stream SHALL produce 0x3F80, 0x000F, 0x0000 in order.
- During the stall, in_ready SHALL be 0 and result SHALL be held.
REQ-036 Reset asserted with 3 products in flight:
- out_valid SHALL be 0 on the next cycle.
- No stale product SHALL appear afterwards.
- The first new input SHALL produce its result 3 cycles after acceptance.
REQ-037 With KARATSUBA_MUL_SIGNED_EN, WIDTH=8:
- 0xFF*0xFF -> 0x0001
- 0x80*0x7F -> 0xC080
- 0x80*0x80 -> 0x4000
REQ-038 Random check: 10k random operand pairs with random out_ready, checked by a scoreboard against a*b.
